// File: rtl/up_down_counter_mod.sv
// -----------------------------------------------------------------------------
// up_down_counter_mod
//   Parametrised synchronous up/down counter. It has a programmable modulus
//   (MAX_VAL+1), a parallel load that clamps to MAX_VAL, and either wrap or
//   saturate behaviour at the limits. It produces a terminal-count flag and
//   one-cycle overflow/underflow pulses. It feeds timers, dividers and
//   sequencers that need a mod-N count in either direction.
//
// Parameters
//   WIDTH     counter width in bits (>=1)
//   MAX_VAL   highest count value, < 2**WIDTH; modulus = MAX_VAL+1
//   SATURATE  0 = wrap at limits, 1 = hold at limits
//   RST_VAL   count value after reset, <= MAX_VAL
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   en        in   1      count enable; 0 = hold
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      parallel load strobe (beats en)
//   load_val  in   WIDTH  value to load, clamped to MAX_VAL
//   cnt       out  WIDTH  current count (registered)
//   tc        out  1      terminal count, combinational from cnt and up
//   ovf       out  1      registered pulse: up-step attempted at MAX_VAL
//   unf       out  1      registered pulse: down-step attempted at 0
// -----------------------------------------------------------------------------
module up_down_counter_mod #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] load_clamped;

  // Limit detection on the registered count
  assign at_max = (cnt_q == MAX_C);
  assign at_min = (cnt_q == ZERO_C);

  // Out-of-range load values clamp so the count never exceeds MAX_VAL
  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

  // Next-state: load > count > hold (reset is applied in the register)
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (load) begin
      cnt_d = load_clamped;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          ovf_d = 1'b1;
          cnt_d = SATURATE ? MAX_C : ZERO_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end else begin
        if (at_min) begin
          unf_d = 1'b1;
          cnt_d = SATURATE ? ZERO_C : MAX_C;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_C;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
  // Terminal count ignores en so that cascaded stages can use en && tc
  assign tc  = up ? at_max : at_min;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter_mod
//   Directed bench for up_down_counter_mod. Three instances share one set of
//   inputs: a wrapping mod-10 counter, a saturating mod-10 counter and a
//   wrapping mod-10 counter with RST_VAL=5.
// -----------------------------------------------------------------------------
module tb_up_down_counter_mod;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] cnt_w, cnt_s, cnt_r;
  logic         tc_w, tc_s, tc_r;
  logic         ovf_w, ovf_s, ovf_r;
  logic         unf_w, unf_s, unf_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  up_down_counter_mod #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1'b0), .RST_VAL(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w)
  );

  up_down_counter_mod #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1'b1), .RST_VAL(0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s)
  );

  up_down_counter_mod #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1'b0), .RST_VAL(5)) dut_rv (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .cnt(cnt_r), .tc(tc_r), .ovf(ovf_r), .unf(unf_r)
  );

  // Advance one rising edge and settle past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic [W-1:0] lv);
    rst = r; en = e; up = u; load = l; load_val = lv;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    checks++;
    if (cnt_w !== 4'd0 || ovf_w !== 1'b0 || unf_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap cnt=%0d ovf=%b unf=%b expected cnt=0 ovf=0 unf=0", cnt_w, ovf_w, unf_w);
    end
    checks++;
    if (cnt_r !== 4'd5) begin
      failures++;
      $display("FAIL reset_rstval cnt=%0d expected 5", cnt_r);
    end
  endtask

  task automatic test_count_up_wrap();
    logic [W-1:0] exp_cnt;
    logic         exp_ovf;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_cnt = W'((i + 1) % 10);
      exp_ovf = (i == 9);
      checks++;
      if (cnt_w !== exp_cnt || ovf_w !== exp_ovf || unf_w !== 1'b0) begin
        failures++;
        $display("FAIL count_up step=%0d cnt=%0d ovf=%b unf=%b expected cnt=%0d ovf=%b unf=0",
                 i, cnt_w, ovf_w, unf_w, exp_cnt, exp_ovf);
      end
    end
  endtask

  task automatic test_count_down_wrap();
    logic [W-1:0] exp_seq [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    checks++;
    if (cnt_w !== 4'd3 || tc_w !== 1'b0) begin
      failures++;
      $display("FAIL load3 cnt=%0d tc=%b expected cnt=3 tc=0", cnt_w, tc_w);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cnt_w !== exp_seq[i] || unf_w !== (exp_seq[i] == 4'd9) ||
          ovf_w !== 1'b0 || tc_w !== (exp_seq[i] == 4'd0)) begin
        failures++;
        $display("FAIL count_down step=%0d cnt=%0d unf=%b ovf=%b tc=%b expected cnt=%0d unf=%b ovf=0 tc=%b",
                 i, cnt_w, unf_w, ovf_w, tc_w, exp_seq[i], exp_seq[i] == 4'd9, exp_seq[i] == 4'd0);
      end
    end
  endtask

  task automatic test_saturate();
    logic exp_ovf [3] = '{1'b0, 1'b1, 1'b1};
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cnt_s !== 4'd9 || ovf_s !== exp_ovf[i] || unf_s !== 1'b0) begin
        failures++;
        $display("FAIL sat_up step=%0d cnt=%0d ovf=%b unf=%b expected cnt=9 ovf=%b unf=0",
                 i, cnt_s, ovf_s, unf_s, exp_ovf[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (cnt_s !== 4'd0 || unf_s !== 1'b1 || ovf_s !== 1'b0 || tc_s !== 1'b1) begin
        failures++;
        $display("FAIL sat_down step=%0d cnt=%0d unf=%b ovf=%b tc=%b expected cnt=0 unf=1 ovf=0 tc=1",
                 i, cnt_s, unf_s, ovf_s, tc_s);
      end
    end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd15);
    tick();
    checks++;
    if (cnt_w !== 4'd9 || cnt_s !== 4'd9) begin
      failures++;
      $display("FAIL load_clamp cnt_wrap=%0d cnt_sat=%0d expected 9 and 9", cnt_w, cnt_s);
    end
    checks++;
    if (tc_w !== 1'b1) begin
      failures++;
      $display("FAIL tc_at_max_up tc=%b expected 1", tc_w);
    end
    // Load beats an up-step that would otherwise overflow
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
    tick();
    checks++;
    if (cnt_w !== 4'd2 || ovf_w !== 1'b0 || unf_w !== 1'b0) begin
      failures++;
      $display("FAIL load_over_en cnt=%0d ovf=%b unf=%b expected cnt=2 ovf=0 unf=0", cnt_w, ovf_w, unf_w);
    end
  endtask

  task automatic test_mid_count_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    checks++;
    if (cnt_w !== 4'd6) begin
      failures++;
      $display("FAIL pre_reset_count cnt=%0d expected 6", cnt_w);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    tick();
    checks++;
    if (cnt_w !== 4'd0 || ovf_w !== 1'b0 || unf_w !== 1'b0 || cnt_r !== 4'd5) begin
      failures++;
      $display("FAIL mid_reset cnt=%0d ovf=%b unf=%b cnt_rv=%0d expected cnt=0 ovf=0 unf=0 cnt_rv=5",
               cnt_w, ovf_w, unf_w, cnt_r);
    end
    // Reset clears a pending overflow pulse
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    checks++;
    if (ovf_w !== 1'b0 || cnt_w !== 4'd0) begin
      failures++;
      $display("FAIL reset_clears_ovf cnt=%0d ovf=%b expected cnt=0 ovf=0", cnt_w, ovf_w);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, i[0], 1'b0, 4'd0);
      tick();
      checks++;
      if (cnt_w !== 4'd7 || ovf_w !== 1'b0 || unf_w !== 1'b0 || tc_w !== 1'b0) begin
        failures++;
        $display("FAIL hold step=%0d cnt=%0d ovf=%b unf=%b tc=%b expected cnt=7 ovf=0 unf=0 tc=0",
                 i, cnt_w, ovf_w, unf_w, tc_w);
      end
    end
    // Hold at 0: tc follows up without a clock edge
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    checks++;
    if (tc_w !== 1'b0) begin
      failures++;
      $display("FAIL tc_zero_up tc=%b expected 0", tc_w);
    end
    up = 1'b0;
    #1;
    checks++;
    if (tc_w !== 1'b1) begin
      failures++;
      $display("FAIL tc_zero_down tc=%b expected 1", tc_w);
    end
  endtask

  task automatic test_back_to_back();
    logic         dirs    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_seq [4] = '{4'd6, 4'd5, 4'd4, 4'd5};
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, dirs[i], 1'b0, 4'd0);
      tick();
      checks++;
      if (cnt_w !== exp_seq[i] || ovf_w !== 1'b0 || unf_w !== 1'b0) begin
        failures++;
        $display("FAIL dir_change step=%0d cnt=%0d ovf=%b unf=%b expected cnt=%0d ovf=0 unf=0",
                 i, cnt_w, ovf_w, unf_w, exp_seq[i]);
      end
    end
    // Flag is a single-cycle pulse: overflow then an ordinary step
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    tick();
    checks++;
    if (cnt_w !== 4'd1 || ovf_w !== 1'b0) begin
      failures++;
      $display("FAIL ovf_single_pulse cnt=%0d ovf=%b expected cnt=1 ovf=0", cnt_w, ovf_w);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    #2;
    test_reset();
    test_count_up_wrap();
    test_count_down_wrap();
    test_saturate();
    test_load();
    test_mid_count_reset();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
